// File: rtl/mem_responder_if.sv
// Request/response channel between the core's load/store path and the memory responder.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: one outstanding word request, programmable access latency,
// byte-masked writes into an internal word array, full-word read responses.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | req_ready=1, waiting for a request handshake
// S_WAIT   | latency down-counter running, request held in capture regs
// S_ACCESS | single cycle: array write or read, response data registered
// S_RESP   | resp_valid=1, data held until the requester takes it
module mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);
  localparam logic [3:0]  LAT  = 4'(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            wen_q, wen_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wmask_q, wmask_d;
  logic            in_range_q, in_range_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [31:0]     resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;

  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     mem_rd;
  logic [31:0]     wr_word;
  logic            mem_we;
  logic [31:0]     off;

  // Unsigned offset from the window base; addresses below the base wrap high and fail the range check.
  assign off = bus.req_addr - BASE_ADDR;

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  // Array read port and byte-merged write word for the captured request.
  always_comb begin
    mem_rd  = mem_q[idx_q];
    wr_word = mem_rd;
    for (int i = 0; i < 4; i++) begin
      if (wmask_q[i]) wr_word[8*i +: 8] = wdata_q[8*i +: 8];
    end
    mem_we = (state_q == S_ACCESS) && wen_q && in_range_q;
  end

  // Next-state and registered-output logic of the request sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    in_range_d   = in_range_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          idx_d       = off[AW+1:2];
          in_range_d  = (off < SPAN);
          wen_d       = bus.req_wen;
          wdata_d     = bus.req_wdata;
          wmask_d     = bus.req_wmask;
          req_ready_d = 1'b0;
          if (LAT == 4'd0) begin
            cnt_d   = 4'd0;
            state_d = S_ACCESS;
          end else begin
            cnt_d   = LAT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
        if (!in_range_q) begin
          resp_rdata_d = 32'h0;
          resp_err_d   = 1'b1;
        end else if (wen_q) begin
          resp_rdata_d = 32'h0;
          resp_err_d   = 1'b0;
        end else begin
          resp_rdata_d = mem_rd;
          resp_err_d   = 1'b0;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and capture registers; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      idx_q        <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= 32'h0;
      wmask_q      <= 4'h0;
      in_range_q   <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      in_range_q   <= in_range_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Word array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= wr_word;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a LATENCY=2 and a LATENCY=0 instance share one request driver,
// selected by 'sel'. Expected responses are queued at issue; a negedge monitor pops and compares.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if b2 ();
  mem_responder_if b0 ();

  mem_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH(1024), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .bus(b2.slave)
  );
  mem_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH(1024), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0.slave)
  );

  logic        sel;
  logic        t_valid;
  logic [31:0] t_addr;
  logic        t_wen;
  logic [31:0] t_wdata;
  logic [3:0]  t_wmask;
  logic        t_resp_ready;

  assign b2.req_valid  = t_valid & ~sel;
  assign b2.req_addr   = t_addr;
  assign b2.req_wen    = t_wen;
  assign b2.req_wdata  = t_wdata;
  assign b2.req_wmask  = t_wmask;
  assign b2.resp_ready = t_resp_ready;
  assign b0.req_valid  = t_valid & sel;
  assign b0.req_addr   = t_addr;
  assign b0.req_wen    = t_wen;
  assign b0.req_wdata  = t_wdata;
  assign b0.req_wmask  = t_wmask;
  assign b0.resp_ready = t_resp_ready;

  logic        cur_req_valid, cur_req_ready, cur_resp_valid, cur_resp_err;
  logic [31:0] cur_resp_rdata;
  assign cur_req_valid  = sel ? b0.req_valid  : b2.req_valid;
  assign cur_req_ready  = sel ? b0.req_ready  : b2.req_ready;
  assign cur_resp_valid = sel ? b0.resp_valid : b2.resp_valid;
  assign cur_resp_rdata = sel ? b0.resp_rdata : b2.resp_rdata;
  assign cur_resp_err   = sel ? b0.resp_err   : b2.resp_err;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: latency, hold-stability, req_ready exclusion and scoreboard pop on every response.
  int          hs_cyc;
  logic        pend, prev_v, after_hs;
  logic [31:0] held_rdata;
  logic        held_err;
  exp_t        e;
  always @(negedge clk) begin
    if (!rst) begin
      pend     = 1'b0;
      prev_v   = 1'b0;
      after_hs = 1'b0;
    end else begin
      if (after_hs) chk("req_ready_after_resp", 32'(cur_req_ready), 32'd1);
      after_hs = 1'b0;
      if (cur_req_valid && cur_req_ready) begin
        hs_cyc = cyc;
        pend   = 1'b1;
      end
      if (cur_resp_valid) begin
        chk("req_ready_while_resp", 32'(cur_req_ready), 32'd0);
        if (!prev_v) begin
          if (pend) chk("latency", 32'(cyc - hs_cyc), sel ? 32'd2 : 32'd4);
          else chk("resp_without_request", 32'd1, 32'd0);
          pend       = 1'b0;
          held_rdata = cur_resp_rdata;
          held_err   = cur_resp_err;
        end else begin
          chk("resp_rdata_stable", cur_resp_rdata, held_rdata);
          chk("resp_err_stable", 32'(cur_resp_err), 32'(held_err));
        end
        if (t_resp_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("resp_rdata", cur_resp_rdata, e.rdata);
            chk("resp_err", 32'(cur_resp_err), 32'(e.err));
          end
          after_hs = 1'b1;
        end
      end
      prev_v = cur_resp_valid;
    end
  end

  // Issue one request; with want_resp=0 it returns one cycle after the request handshake.
  task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] m, input logic want_resp,
                        input logic [31:0] er, input logic ee, input int bp);
    logic ok;
    exp_t x;
    if (want_resp) begin
      x.rdata = er;
      x.err   = ee;
      exp_q.push_back(x);
    end
    @(posedge clk); #1;
    t_valid = 1'b1; t_addr = a; t_wen = w; t_wdata = d; t_wmask = m;
    t_resp_ready = (bp == 0);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (cur_req_ready) begin ok = 1'b1; break; end
    end
    chk("req_handshake_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    // Scramble request fields so late sampling would corrupt the result.
    t_valid = 1'b0; t_addr = 32'h8000_0FF8; t_wen = ~w; t_wdata = 32'h5A5A_A5A5; t_wmask = 4'hF;
    if (!want_resp) return;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (cur_resp_valid) begin ok = 1'b1; break; end
    end
    chk("resp_timeout", 32'(ok), 32'd1);
    if (!ok) return;
    if (bp > 0) begin
      repeat (bp) @(posedge clk);
      #1 t_resp_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; t_valid = 1'b0; t_addr = 32'h0; t_wen = 1'b0;
    t_wdata = 32'h0; t_wmask = 4'h0; t_resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready",  32'(b2.req_ready),  32'd1);
    chk("rst_resp_valid", 32'(b2.resp_valid), 32'd0);
    chk("rst_resp_rdata", b2.resp_rdata,      32'd0);
    chk("rst_resp_err",   32'(b2.resp_err),   32'd0);
    chk("rst0_req_ready", 32'(b0.req_ready),  32'd1);
    chk("rst0_resp_valid",32'(b0.resp_valid), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Full-word write then read with ignored low address bits.
    do_req(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0, 1'b0, 0);
    do_req(32'h8000_0013, 1'b0, 32'h1357_9BDF, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 0);

    // Byte-masked writes.
    do_req(32'h8000_0030, 1'b1, 32'h1122_3344, 4'hF, 1'b1, 32'h0, 1'b0, 0);
    do_req(32'h8000_0030, 1'b1, 32'hAABB_CCDD, 4'b0100, 1'b1, 32'h0, 1'b0, 0);
    do_req(32'h8000_0030, 1'b0, 32'h0, 4'h0, 1'b1, 32'h11BB_3344, 1'b0, 0);
    do_req(32'h8000_0030, 1'b1, 32'h0000_5566, 4'b0011, 1'b1, 32'h0, 1'b0, 0);
    do_req(32'h8000_0030, 1'b0, 32'h0, 4'hF, 1'b1, 32'h11BB_5566, 1'b0, 0);

    // Range boundaries; out-of-range writes must not alias onto in-range words.
    do_req(32'h8000_0000, 1'b1, 32'h0BAD_F00D, 4'hF, 1'b1, 32'h0, 1'b0, 0);
    do_req(32'h8000_0FFC, 1'b1, 32'h1234_5678, 4'hF, 1'b1, 32'h0, 1'b0, 0);
    do_req(32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, 0);
    do_req(32'h8000_1000, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, 0);
    do_req(32'h8000_1000, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0, 1'b1, 0);
    do_req(32'h7FFF_FFFC, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0, 1'b1, 0);
    do_req(32'h8000_0000, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0BAD_F00D, 1'b0, 0);
    do_req(32'h8000_0FFC, 1'b0, 32'h0, 4'h0, 1'b1, 32'h1234_5678, 1'b0, 0);

    // Response backpressure for 5 cycles.
    do_req(32'h8000_0010, 1'b0, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 5);
    do_req(32'h8000_1004, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, 5);

    // Reset during WAIT drops the pending write and its response.
    do_req(32'h8000_0020, 1'b1, 32'h0, 4'hF, 1'b1, 32'h0, 1'b0, 0);
    do_req(32'h8000_0020, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0, 1'b0, 0);
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready",  32'(b2.req_ready),  32'd1);
    chk("post_rst_resp_valid", 32'(b2.resp_valid), 32'd0);
    repeat (10) @(negedge clk);
    do_req(32'h8000_0020, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, 0);

    // LATENCY=0 instance.
    sel = 1'b1;
    do_req(32'h8000_0040, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b1, 32'h0, 1'b0, 0);
    do_req(32'h8000_0040, 1'b1, 32'hFFFF_FFFF, 4'h0, 1'b1, 32'h0, 1'b0, 0);
    do_req(32'h8000_0040, 1'b0, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 0);
    do_req(32'h8000_1000, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, 3);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
